// File: rtl/alu_risc_pkg.sv
// Shared opcodes, FSM encoding and width helper for the RISC-SPM multi-cycle ALU.
package alu_risc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_EQZ = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hB;
  localparam logic [3:0] OP_XOR = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SHR = 4'hE;
  localparam logic [3:0] OP_MUL = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic int unsigned shamt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/alu_risc_mul_seq.sv
// Radix-2 shift-add unsigned multiplier; product_c is the product after the current step.
module alu_risc_mul_seq
  import alu_risc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic [WORD_SIZE-1:0]     mcand,
  input  logic [WORD_SIZE-1:0]     mplier,
  output logic                     last_c,
  output logic [2*WORD_SIZE-1:0]   product_c
);

  localparam int unsigned CNT_W = shamt_width(WORD_SIZE);

  logic [WORD_SIZE-1:0] mcand_q, mcand_d;
  logic [WORD_SIZE-1:0] hi_q, hi_d;
  logic [WORD_SIZE-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_SIZE:0]   sum_c;

  // lo holds the unconsumed multiplier bits; product bits shift in from the top
  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : (WORD_SIZE + 1)'(0));
    if (load) begin
      mcand_d = mcand;
      hi_d    = '0;
      lo_d    = mplier;
      cnt_d   = '0;
    end else if (step) begin
      hi_d    = sum_c[WORD_SIZE:1];
      lo_d    = {sum_c[0], lo_q[WORD_SIZE-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign last_c    = step && (cnt_q == CNT_W'(WORD_SIZE - 1));
  assign product_c = {hi_d, lo_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_risc_mc.sv
// Registered multi-cycle ALU for RISC-SPM: single-cycle logic/arith/shift ops
// plus a sequential multiplier behind a start/busy/done handshake.
module alu_risc_mc
  import alu_risc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned OP_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OP_SIZE-1:0]   sel,
  input  logic [WORD_SIZE-1:0] data_1,
  input  logic [WORD_SIZE-1:0] data_2,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] alu_out,
  output logic [WORD_SIZE-1:0] alu_out_hi,
  output logic                 zero_flag,
  output logic                 carry_flag,
  output logic                 neg_flag,
  output logic                 ovf_flag
);

  localparam int unsigned SH_W = shamt_width(WORD_SIZE);

  state_e               state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [WORD_SIZE-1:0] lo_q, lo_d, hi_q, hi_d;
  logic                 z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;

  logic [SH_W-1:0]        amt_c;
  logic [WORD_SIZE:0]     add_c, sub_c, shl_c, shr_c;
  logic [WORD_SIZE-1:0]   res_c;
  logic                   carry_c, ovf_c;
  logic                   mul_load, mul_step, mul_last_c;
  logic [2*WORD_SIZE-1:0] mul_prod_c;

  alu_risc_mul_seq #(.WORD_SIZE(WORD_SIZE)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .mcand     (data_2),
    .mplier    (data_1),
    .last_c    (mul_last_c),
    .product_c (mul_prod_c)
  );

  // Single-cycle datapath; shifts carry one guard bit to catch the last bit out
  always_comb begin
    amt_c   = data_1[SH_W-1:0];
    add_c   = {1'b0, data_1} + {1'b0, data_2};
    sub_c   = {1'b0, data_2} - {1'b0, data_1};
    shl_c   = {1'b0, data_2} << amt_c;
    shr_c   = {data_2, 1'b0} >> amt_c;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (sel)
      OP_SIZE'(OP_ADD): begin
        res_c   = add_c[WORD_SIZE-1:0];
        carry_c = add_c[WORD_SIZE];
        ovf_c   = (data_1[WORD_SIZE-1] == data_2[WORD_SIZE-1]) &&
                  (add_c[WORD_SIZE-1] != data_1[WORD_SIZE-1]);
      end
      OP_SIZE'(OP_SUB), OP_SIZE'(OP_EQZ): begin
        res_c   = sub_c[WORD_SIZE-1:0];
        carry_c = sub_c[WORD_SIZE];
        ovf_c   = (data_1[WORD_SIZE-1] != data_2[WORD_SIZE-1]) &&
                  (sub_c[WORD_SIZE-1] != data_2[WORD_SIZE-1]);
      end
      OP_SIZE'(OP_AND): res_c = data_1 & data_2;
      OP_SIZE'(OP_NOT): res_c = ~data_2;
      OP_SIZE'(OP_OR):  res_c = data_1 | data_2;
      OP_SIZE'(OP_XOR): res_c = data_1 ^ data_2;
      OP_SIZE'(OP_SHL): begin
        res_c   = shl_c[WORD_SIZE-1:0];
        carry_c = shl_c[WORD_SIZE];
      end
      OP_SIZE'(OP_SHR): begin
        res_c   = shr_c[WORD_SIZE:1];
        carry_c = shr_c[0];
      end
      default: res_c = '0;
    endcase
  end

  // FSM next-state and output-register updates
  always_comb begin
    state_d  = state_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    lo_d     = lo_q;
    hi_d     = hi_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (sel == OP_SIZE'(OP_MUL)) begin
            mul_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_MUL;
          end else begin
            done_d = 1'b1;
            lo_d   = res_c;
            hi_d   = '0;
            z_d    = ~|res_c;
            c_d    = carry_c;
            n_d    = res_c[WORD_SIZE-1];
            v_d    = ovf_c;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        busy_d   = 1'b1;
        if (mul_last_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          {hi_d, lo_d} = mul_prod_c;
          z_d     = ~|mul_prod_c;
          c_d     = |mul_prod_c[2*WORD_SIZE-1:WORD_SIZE];
          n_d     = mul_prod_c[2*WORD_SIZE-1];
          v_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign alu_out    = lo_q;
  assign alu_out_hi = hi_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign neg_flag   = n_q;
  assign ovf_flag   = v_q;

endmodule

// File: tb/tb_alu_risc_mc.sv
// Randomized and directed self-checking bench for alu_risc_mc (WORD_SIZE=8).
module tb_alu_risc_mc;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   sel;
  logic [W-1:0] data_1, data_2;
  logic         busy, done;
  logic [W-1:0] alu_out, alu_out_hi;
  logic         zero_flag, carry_flag, neg_flag, ovf_flag;

  int n_checks = 0;
  int n_pass   = 0;

  alu_risc_mc #(.WORD_SIZE(W), .OP_SIZE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sel        (sel),
    .data_1     (data_1),
    .data_2     (data_2),
    .busy       (busy),
    .done       (done),
    .alu_out    (alu_out),
    .alu_out_hi (alu_out_hi),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .neg_flag   (neg_flag),
    .ovf_flag   (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer arithmetic straight from the opcode definitions
  function automatic void model(input logic [3:0] op, input logic [7:0] d1, input logic [7:0] d2,
                                output logic [7:0] lo, output logic [7:0] hi, output logic [3:0] zcnv);
    int a, b, sa, sb, r, sv, amt;
    logic z, c, n, v;
    a = int'(d1); b = int'(d2);
    sa = int'($signed(d1)); sb = int'($signed(d2));
    amt = a % 8;
    r = 0; c = 0; v = 0; hi = 8'h00;
    case (op)
      4'h1: begin r = a + b; c = (r > 255); sv = sa + sb; v = (sv > 127) || (sv < -128); end
      4'h2, 4'h9: begin r = b - a; c = (b < a); sv = sb - sa; v = (sv > 127) || (sv < -128); end
      4'h3: r = a & b;
      4'h4: r = 255 - b;
      4'hB: r = a | b;
      4'hC: r = a ^ b;
      4'hD: begin r = b << amt; c = (amt != 0) && (((b << amt) >> 8) % 2 == 1); end
      4'hE: begin r = b >> amt; c = (amt != 0) && (((b >> (amt - 1)) % 2) == 1); end
      4'hF: r = a * b;
      default: r = 0;
    endcase
    lo = 8'(r);
    if (op == 4'hF) begin
      hi = 8'(r / 256);
      c  = (hi != 0);
      n  = hi[7];
      z  = (r == 0);
    end else begin
      n = lo[7];
      z = (lo == 0);
    end
    zcnv = {z, c, n, v};
  endfunction

  task automatic check_result(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] lo, hi;
    logic [3:0] f;
    model(op, a, b, lo, hi, f);
    check({tag, " lo"}, alu_out, lo);
    check({tag, " hi"}, alu_out_hi, hi);
    check({tag, " zcnv"}, {zero_flag, carry_flag, neg_flag, ovf_flag}, f);
  endtask

  task automatic single(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit keep, input string tag);
    start = 1'b1; sel = op; data_1 = a; data_2 = b;
    tick();
    check({tag, " done"}, done, 1);
    check({tag, " busy"}, busy, 0);
    check_result(tag, op, a, b);
    if (!keep) start = 1'b0;
  endtask

  task automatic mul_op(input logic [7:0] a, input logic [7:0] b, input bit inject, input string tag);
    int e, bc;
    start = 1'b1; sel = 4'hF; data_1 = a; data_2 = b;
    tick();
    start = 1'b0;
    check({tag, " done at accept"}, done, 0);
    e = 0; bc = 0;
    while (done !== 1'b1 && e < 40) begin
      if (busy === 1'b1) bc++;
      if (inject && e == 3) begin
        start = 1'b1; sel = 4'h1; data_1 = 8'h11; data_2 = 8'h22;
      end else begin
        start = 1'b0;
        data_1 = 8'($urandom); data_2 = 8'($urandom);
      end
      tick();
      e++;
    end
    check({tag, " latency"}, e, W);
    check({tag, " busy cycles"}, bc, W);
    check({tag, " busy at done"}, busy, 0);
    check_result(tag, 4'hF, a, b);
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] a, b, last_lo;
    int         dones;

    rst = 1'b1; start = 1'b0; sel = 4'h0; data_1 = '0; data_2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset out", {alu_out_hi, alu_out}, 0);
    check("reset flags", {zero_flag, carry_flag, neg_flag, ovf_flag}, 0);
    check("reset busy/done", {busy, done}, 0);

    single(4'h1, 8'hFF, 8'h01, 0, "add ff+01");
    check("add ff+01 zcnv const", {zero_flag, carry_flag, neg_flag, ovf_flag}, 4'b1100);
    single(4'h1, 8'h7F, 8'h01, 0, "add 7f+01");
    check("add 7f+01 zcnv const", {zero_flag, carry_flag, neg_flag, ovf_flag}, 4'b0011);
    single(4'h2, 8'h05, 8'h03, 0, "sub 3-5");
    check("sub 3-5 out const", alu_out, 8'hFE);
    single(4'h9, 8'h05, 8'h05, 0, "eqz");
    single(4'hD, 8'h03, 8'hA5, 0, "shl 3");
    check("shl 3 out const", {alu_out, carry_flag}, {8'h28, 1'b1});
    single(4'hE, 8'h08, 8'hA5, 0, "shr 0");
    single(4'h5, 8'h12, 8'h34, 0, "unused 5");
    tick();
    check("idle done", done, 0);
    check_result("idle hold", 4'h5, 8'h12, 8'h34);

    mul_op(8'hFF, 8'hFF, 1, "mul ff*ff");
    check("mul ff*ff const", {alu_out_hi, alu_out, carry_flag, neg_flag}, {8'hFE, 8'h01, 1'b1, 1'b1});
    tick();
    check("no queued add", done, 0);
    check_result("mul hold", 4'hF, 8'hFF, 8'hFF);

    // Abort a multiply with reset in its fourth busy cycle
    start = 1'b1; sel = 4'hF; data_1 = 8'h12; data_2 = 8'h34;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst out", {alu_out_hi, alu_out}, 0);
    check("rst flags", {zero_flag, carry_flag, neg_flag, ovf_flag}, 0);
    check("rst busy/done", {busy, done}, 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("no done after abort", dones, 0);
    single(4'h1, 8'h02, 8'h03, 0, "add 2+3 post rst");

    // Five back-to-back ADDs
    last_lo = '0;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      single(4'h1, a, b, 1, "b2b add");
      last_lo = 8'(a + b);
    end
    start = 1'b0;
    tick();
    check("b2b end done", done, 0);
    check("b2b hold", alu_out, last_lo);

    // Second multiply starts in the cycle the first completes
    mul_op(8'h0D, 8'hB7, 0, "mul a");
    mul_op(8'h80, 8'h02, 0, "mul b");
    mul_op(8'h00, 8'h9C, 0, "mul zero");

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (op == 4'hF) mul_op(a, b, bit'($urandom_range(0, 1)), "rnd mul");
      else single(op, a, b, bit'($urandom_range(0, 1)), "rnd op");
    end
    start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
